sccb_init_sequencer: RTL and testbench



---
 rtl/sccb_init_sequencer_if.sv | 26 ++
 rtl/sccb_init_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_init_sequencer_if.sv
// Bundle of the table-lookup, SCCB pin and status signals around the init sequencer.
// The master modport is the sequencer side; the slave modport is the table/pad/host side.
interface sccb_init_sequencer_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic [IDX_W-1:0] table_index;
  logic [15:0]      table_data;
  logic [IDX_W-1:0] table_size;
  logic             sccb_scl;
  logic             sccb_sda_oe;
  logic             sccb_sda_in;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    input  start, table_data, table_size, sccb_sda_in,
    output table_index, sccb_scl, sccb_sda_oe, busy, done, error
  );

  modport slave (
    output start, table_data, table_size, sccb_sda_in,
    input  table_index, sccb_scl, sccb_sda_oe, busy, done, error
  );
endinterface

// File: rtl/sccb_init_sequencer.sv
// Camera init engine: walks a {reg_addr, reg_data} table and issues one 3-byte SCCB write
// per entry, with power-up wait, delay-tag entries, post-soft-reset delay and optional ACK retry.
module sccb_init_sequencer #(
  parameter int          CLK_HZ       = 25_000_000,
  parameter int          SCCB_HZ      = 100_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h60,
  parameter int          IDX_W        = 8,
  parameter int          PWR_WAIT     = 250_000,
  parameter logic [15:0] DELAY_TAG    = 16'hFFF0,
  parameter int          DELAY_CYC    = 25_000,
  parameter logic [7:0]  SOFT_RST_REG = 8'h12,
  parameter int          ACK_CHECK    = 0,
  parameter int          RETRIES      = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  sccb_init_sequencer_if.master bus
);

  localparam int          Q_CYC    = CLK_HZ / (4 * SCCB_HZ);
  localparam logic [15:0] Q_LAST   = 16'(Q_CYC - 1);
  localparam logic [31:0] PWR_LAST = 32'(PWR_WAIT - 1);
  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYC - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(RETRIES);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PWR   = 4'd1;
  localparam logic [3:0] S_FETCH = 4'd2;
  localparam logic [3:0] S_START = 4'd3;
  localparam logic [3:0] S_TX    = 4'd4;
  localparam logic [3:0] S_STOP  = 4'd5;
  localparam logic [3:0] S_GAP   = 4'd6;
  localparam logic [3:0] S_DLY   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_ERR   = 4'd9;

  logic [3:0]       r_state;
  logic [15:0]      r_qcnt;
  logic [1:0]       r_q;
  logic [3:0]       r_bit;
  logic [1:0]       r_byte;
  logic [31:0]      r_cnt;
  logic [7:0]       r_retry;
  logic             r_nack;
  logic [15:0]      r_entry;
  logic [IDX_W-1:0] r_index;
  logic             r_scl;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_div_run;
  logic             w_tick;
  logic             w_qend;
  logic             w_bus_phase;
  logic [7:0]       w_byte;
  logic             w_bit;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_last;
  logic             w_soft;
  logic             w_scl;
  logic             w_sda_oe;

  assign w_div_run   = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
  assign w_tick      = w_div_run && (r_qcnt == Q_LAST);
  assign w_qend      = w_tick && (r_q == 2'd3);
  assign w_bus_phase = (r_state == S_START) || (r_state == S_TX) ||
                       (r_state == S_STOP)  || (r_state == S_GAP);
  assign w_byte      = (r_byte == 2'd0) ? DEV_ADDR :
                       (r_byte == 2'd1) ? r_entry[15:8] : r_entry[7:0];
  assign w_bit       = w_byte[3'd7 - r_bit[2:0]];
  assign w_next_idx  = r_index + 1'b1;
  assign w_last      = (w_next_idx == bus.table_size);
  assign w_soft      = (r_entry[15:8] == SOFT_RST_REG) && r_entry[7];

  // Pin levels for the current quarter; registered below so the pads never see decode glitches.
  always_comb begin
    w_scl    = 1'b1;
    w_sda_oe = 1'b0;
    case (r_state)
      S_START: begin
        w_scl    = (r_q != 2'd3);
        w_sda_oe = (r_q != 2'd0);
      end
      S_TX: begin
        w_scl    = r_q[1];
        w_sda_oe = (r_bit == 4'd8) ? 1'b0 : ~w_bit;
      end
      S_STOP: begin
        w_scl    = (r_q != 2'd0);
        w_sda_oe = (r_q != 2'd3);
      end
      default: begin
        w_scl    = 1'b1;
        w_sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_qcnt   <= '0;
      r_q      <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_cnt    <= '0;
      r_retry  <= '0;
      r_nack   <= 1'b0;
      r_entry  <= '0;
      r_index  <= '0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_scl    <= w_scl;
      r_sda_oe <= w_sda_oe;

      // FETCH realigns the divider so every START/TX/STOP/GAP quarter is exactly Q_CYC long.
      if (!w_div_run || (r_state == S_FETCH) || w_tick)
        r_qcnt <= '0;
      else
        r_qcnt <= r_qcnt + 16'd1;

      if (w_tick && w_bus_phase)
        r_q <= r_q + 2'd1;

      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_index <= '0;
            r_retry <= '0;
            r_cnt   <= '0;
            r_error <= 1'b0;
            if (bus.table_size == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_PWR;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end
        end

        S_PWR: begin
          if (r_cnt == PWR_LAST)
            r_state <= S_FETCH;
          else
            r_cnt <= r_cnt + 32'd1;
        end

        S_FETCH: begin
          r_entry <= bus.table_data;
          r_q     <= '0;
          r_cnt   <= '0;
          r_state <= (bus.table_data == DELAY_TAG) ? S_DLY : S_START;
        end

        S_START: begin
          if (w_qend) begin
            r_state <= S_TX;
            r_bit   <= '0;
            r_byte  <= '0;
            r_nack  <= 1'b0;
          end
        end

        S_TX: begin
          if (w_tick && (r_q == 2'd2) && (r_bit == 4'd8) && (ACK_CHECK != 0) && bus.sccb_sda_in)
            r_nack <= 1'b1;
          if (w_qend) begin
            if (r_bit == 4'd8) begin
              r_bit <= '0;
              if (r_nack || (r_byte == 2'd2))
                r_state <= S_STOP;
              else
                r_byte <= r_byte + 2'd1;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end

        S_STOP: begin
          if (w_qend)
            r_state <= S_GAP;
        end

        S_GAP: begin
          if (w_qend) begin
            if (r_nack) begin
              if (r_retry >= RETRY_MAX) begin
                r_state <= S_ERR;
                r_busy  <= 1'b0;
                r_error <= 1'b1;
              end else begin
                r_retry <= r_retry + 8'd1;
                r_state <= S_FETCH;
              end
            end else if (w_soft) begin
              r_cnt   <= '0;
              r_state <= S_DLY;
            end else begin
              r_index <= w_next_idx;
              r_retry <= '0;
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_FETCH;
              end
            end
          end
        end

        S_DLY: begin
          if (r_cnt == DLY_LAST) begin
            r_index <= w_next_idx;
            r_retry <= '0;
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.table_index = r_index;
  assign bus.sccb_scl    = r_scl;
  assign bus.sccb_sda_oe = r_sda_oe;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Directed bench for sccb_init_sequencer: one DUT without ACK checking, one with ACK checking,
// an SCCB line monitor that decodes START/STOP/bytes and measures SCL phase lengths.
module tb_sccb_init_sequencer;

  localparam int Q   = 4;
  localparam int PWR = 60;
  localparam int DLY = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sccb_init_sequencer_if #(.IDX_W(8)) ifA ();
  sccb_init_sequencer_if #(.IDX_W(8)) ifB ();

  logic [15:0] tbl [0:7];
  assign ifA.table_data = tbl[ifA.table_index[2:0]];
  assign ifB.table_data = tbl[ifB.table_index[2:0]];

  sccb_init_sequencer #(
    .CLK_HZ(1_600_000), .SCCB_HZ(100_000), .PWR_WAIT(PWR), .DELAY_CYC(DLY), .ACK_CHECK(0)
  ) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));

  sccb_init_sequencer #(
    .CLK_HZ(1_600_000), .SCCB_HZ(100_000), .PWR_WAIT(PWR), .DELAY_CYC(DLY), .ACK_CHECK(1),
    .RETRIES(3)
  ) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  // Line monitor; SDA line level is the inverse of the open-drain enable.
  int         cyc = 0;
  logic       pSclA = 1'b1, pSdaA = 1'b1, pSclB = 1'b1, pSdaB = 1'b1;
  int         startsA = 0, stopsA = 0, nBytesA = 0, hi2QA = 0, lo2QA = 0, edgesA = 0;
  int         lastEdgeA = 0, bitCntA = 0;
  logic [7:0] shA = 8'h00;
  logic [7:0] bytesA [0:255];
  int         startCycA [0:63];
  int         stopCycA [0:63];
  int         startsB = 0, stopsB = 0, edgesB = 0;
  logic       sA, dA, sB, dB;

  always @(posedge clk) begin
    cyc = cyc + 1;
    sA = ifA.sccb_scl;
    dA = ~ifA.sccb_sda_oe;
    if (sA && pSclA) begin
      if (pSdaA && !dA) begin startCycA[startsA % 64] = cyc; startsA++; bitCntA = 0; end
      if (!pSdaA && dA) begin stopCycA[stopsA % 64] = cyc; stopsA++; end
    end
    if (sA != pSclA) begin
      if (pSclA && (cyc - lastEdgeA == 2 * Q)) hi2QA++;
      if (!pSclA && (cyc - lastEdgeA == 2 * Q)) lo2QA++;
      lastEdgeA = cyc;
      edgesA++;
      if (sA) begin
        if (bitCntA < 8) shA = {shA[6:0], dA};
        if (bitCntA == 7) begin bytesA[nBytesA % 256] = shA; nBytesA++; end
        bitCntA = (bitCntA >= 8) ? 0 : bitCntA + 1;
      end
    end
    pSclA = sA;
    pSdaA = dA;
    sB = ifB.sccb_scl;
    dB = ~ifB.sccb_sda_oe;
    if (sB && pSclB && pSdaB && !dB) startsB++;
    if (sB && pSclB && !pSdaB && dB) stopsB++;
    if (sB != pSclB) edgesB++;
    pSclB = sB;
    pSdaB = dB;
  end

  task automatic applyStimulus(input bit useB);
    @(negedge clk);
    if (useB) ifB.start = 1'b1;
    else      ifA.start = 1'b1;
    @(negedge clk);
    ifA.start = 1'b0;
    ifB.start = 1'b0;
  endtask

  task automatic loadMainTable();
    tbl[0] = 16'hFF01; tbl[1] = 16'h1280; tbl[2] = 16'hFF00; tbl[3] = 16'h0000;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ifA.sccb_scl !== 1'b1)    begin errors++; $display("[TB] FAIL reset_scl got %b want 1", ifA.sccb_scl); end
    checks++; if (ifA.sccb_sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_sda_oe got %b want 0", ifA.sccb_sda_oe); end
    checks++; if (ifA.table_index !== 8'd0) begin errors++; $display("[TB] FAIL reset_index got %0d want 0", ifA.table_index); end
    checks++; if (ifA.busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy got %b want 0", ifA.busy); end
    checks++; if (ifA.done !== 1'b0)        begin errors++; $display("[TB] FAIL reset_done got %b want 0", ifA.done); end
    checks++; if (ifA.error !== 1'b0)       begin errors++; $display("[TB] FAIL reset_error got %b want 0", ifA.error); end
    checks++; if (ifB.sccb_scl !== 1'b1)    begin errors++; $display("[TB] FAIL reset_scl_b got %b want 1", ifB.sccb_scl); end
    checks++; if (ifB.busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy_b got %b want 0", ifB.busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequence();
    int b0, s0, so0, h0, l0, t0, d;
    logic [7:0] expB [0:8];
    expB = '{8'h60, 8'hFF, 8'h01, 8'h60, 8'h12, 8'h80, 8'h60, 8'hFF, 8'h00};
    loadMainTable();
    ifA.table_size = 8'd3;
    b0 = nBytesA; s0 = startsA; so0 = stopsA; h0 = hi2QA; l0 = lo2QA; t0 = cyc;
    applyStimulus(1'b0);
    checks++; if (ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL seq_busy got %b want 1", ifA.busy); end
    for (int i = 0; i < 5000 && !(ifA.done || ifA.error); i++) @(negedge clk);
    checks++; if (ifA.done !== 1'b1) begin errors++; $display("[TB] FAIL seq_done got %b want 1", ifA.done); end
    checks++; if (ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL seq_busy_end got %b want 0", ifA.busy); end
    checks++; if (ifA.table_index !== 8'd3) begin errors++; $display("[TB] FAIL seq_index got %0d want 3", ifA.table_index); end
    checks++; if (startsA - s0 != 3) begin errors++; $display("[TB] FAIL seq_writes got %0d want 3", startsA - s0); end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (bytesA[(b0 + k) % 256] !== expB[k]) begin
        errors++; $display("[TB] FAIL seq_byte%0d got %h want %h", k, bytesA[(b0 + k) % 256], expB[k]);
      end
    end
    checks++; if (hi2QA - h0 != 81) begin errors++; $display("[TB] FAIL seq_scl_high got %0d want 81", hi2QA - h0); end
    checks++; if (lo2QA - l0 != 78) begin errors++; $display("[TB] FAIL seq_scl_low got %0d want 78", lo2QA - l0); end
    d = startCycA[s0 % 64] - t0;
    checks++; if (d < PWR || d > PWR + 30) begin errors++; $display("[TB] FAIL seq_pwr_wait got %0d want %0d..%0d", d, PWR, PWR + 30); end
    d = startCycA[(s0 + 1) % 64] - stopCycA[so0 % 64];
    checks++; if (d >= 60) begin errors++; $display("[TB] FAIL seq_gap1 got %0d want <60", d); end
    d = startCycA[(s0 + 2) % 64] - stopCycA[(so0 + 1) % 64];
    checks++; if (d < DLY || d > DLY + 60) begin errors++; $display("[TB] FAIL seq_softrst_gap got %0d want %0d..%0d", d, DLY, DLY + 60); end
  endtask

  task automatic test_delay_tag();
    int b0, s0, so0, d;
    logic [7:0] expB [0:5];
    expB = '{8'h60, 8'hFF, 8'h01, 8'h60, 8'hFF, 8'h00};
    tbl[0] = 16'hFF01; tbl[1] = 16'hFFF0; tbl[2] = 16'hFF00;
    ifA.table_size = 8'd3;
    b0 = nBytesA; s0 = startsA; so0 = stopsA;
    applyStimulus(1'b0);
    for (int i = 0; i < 5000 && !(ifA.done || ifA.error); i++) @(negedge clk);
    checks++; if (ifA.done !== 1'b1) begin errors++; $display("[TB] FAIL tag_done got %b want 1", ifA.done); end
    checks++; if (startsA - s0 != 2) begin errors++; $display("[TB] FAIL tag_writes got %0d want 2", startsA - s0); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bytesA[(b0 + k) % 256] !== expB[k]) begin
        errors++; $display("[TB] FAIL tag_byte%0d got %h want %h", k, bytesA[(b0 + k) % 256], expB[k]);
      end
    end
    d = startCycA[(s0 + 1) % 64] - stopCycA[so0 % 64];
    checks++; if (d < DLY || d > DLY + 60) begin errors++; $display("[TB] FAIL tag_gap got %0d want %0d..%0d", d, DLY, DLY + 60); end
  endtask

  task automatic test_start_ignored();
    int s0;
    loadMainTable();
    ifA.table_size = 8'd3;
    s0 = startsA;
    applyStimulus(1'b0);
    for (int i = 0; i < 3000 && ifA.table_index != 8'd1; i++) @(negedge clk);
    applyStimulus(1'b0);
    @(negedge clk);
    checks++; if (ifA.table_index !== 8'd1) begin errors++; $display("[TB] FAIL ign_index got %0d want 1", ifA.table_index); end
    checks++; if (ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL ign_busy got %b want 1", ifA.busy); end
    for (int i = 0; i < 5000 && !(ifA.done || ifA.error); i++) @(negedge clk);
    checks++; if (ifA.done !== 1'b1) begin errors++; $display("[TB] FAIL ign_done got %b want 1", ifA.done); end
    checks++; if (startsA - s0 != 3) begin errors++; $display("[TB] FAIL ign_writes got %0d want 3", startsA - s0); end
  endtask

  task automatic test_nack_retry();
    int s0;
    loadMainTable();
    ifB.table_size  = 8'd3;
    ifB.sccb_sda_in = 1'b1;
    s0 = startsB;
    applyStimulus(1'b1);
    for (int i = 0; i < 5000 && !(ifB.done || ifB.error); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++; if (ifB.error !== 1'b1) begin errors++; $display("[TB] FAIL nack_error got %b want 1", ifB.error); end
    checks++; if (ifB.busy !== 1'b0) begin errors++; $display("[TB] FAIL nack_busy got %b want 0", ifB.busy); end
    checks++; if (ifB.done !== 1'b0) begin errors++; $display("[TB] FAIL nack_done got %b want 0", ifB.done); end
    checks++; if (ifB.sccb_scl !== 1'b1) begin errors++; $display("[TB] FAIL nack_scl got %b want 1", ifB.sccb_scl); end
    checks++; if (ifB.sccb_sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL nack_sda_oe got %b want 0", ifB.sccb_sda_oe); end
    checks++; if (startsB - s0 != 4) begin errors++; $display("[TB] FAIL nack_attempts got %0d want 4", startsB - s0); end
    checks++; if (ifB.table_index !== 8'd0) begin errors++; $display("[TB] FAIL nack_index got %0d want 0", ifB.table_index); end
  endtask

  task automatic test_size_zero();
    int e0;
    ifB.table_size = 8'd0;
    e0 = edgesB;
    applyStimulus(1'b1);
    @(negedge clk);
    checks++; if (ifB.done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %b want 1", ifB.done); end
    checks++; if (ifB.busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy got %b want 0", ifB.busy); end
    checks++; if (ifB.error !== 1'b0) begin errors++; $display("[TB] FAIL zero_error got %b want 0", ifB.error); end
    checks++; if (edgesB != e0) begin errors++; $display("[TB] FAIL zero_scl_edges got %0d want %0d", edgesB, e0); end
  endtask

  task automatic test_nack_once();
    int s0, so0;
    loadMainTable();
    ifB.table_size  = 8'd3;
    ifB.sccb_sda_in = 1'b1;
    s0 = startsB; so0 = stopsB;
    applyStimulus(1'b1);
    for (int i = 0; i < 3000 && stopsB == so0; i++) @(negedge clk);
    checks++; if (stopsB == so0) begin errors++; $display("[TB] FAIL once_first_stop got %0d want >%0d", stopsB, so0); end
    ifB.sccb_sda_in = 1'b0;
    for (int i = 0; i < 5000 && !(ifB.done || ifB.error); i++) @(negedge clk);
    checks++; if (ifB.done !== 1'b1) begin errors++; $display("[TB] FAIL once_done got %b want 1", ifB.done); end
    checks++; if (ifB.error !== 1'b0) begin errors++; $display("[TB] FAIL once_error got %b want 0", ifB.error); end
    checks++; if (startsB - s0 != 4) begin errors++; $display("[TB] FAIL once_writes got %0d want 4", startsB - s0); end
  endtask

  task automatic test_reset_mid();
    int b0, s0;
    logic [7:0] expB [0:2];
    expB = '{8'h60, 8'hFF, 8'h01};
    loadMainTable();
    ifA.table_size = 8'd3;
    b0 = nBytesA;
    applyStimulus(1'b0);
    for (int i = 0; i < 3000 && nBytesA < b0 + 4; i++) @(negedge clk);
    checks++; if (nBytesA < b0 + 4) begin errors++; $display("[TB] FAIL mid_progress got %0d want %0d", nBytesA - b0, 4); end
    repeat (26) @(negedge clk);
    checks++; if (ifA.sccb_sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_sda_oe got %b want 1", ifA.sccb_sda_oe); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifA.sccb_scl !== 1'b1)    begin errors++; $display("[TB] FAIL mid_scl got %b want 1", ifA.sccb_scl); end
    checks++; if (ifA.sccb_sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL mid_sda_oe got %b want 0", ifA.sccb_sda_oe); end
    checks++; if (ifA.table_index !== 8'd0) begin errors++; $display("[TB] FAIL mid_index got %0d want 0", ifA.table_index); end
    checks++; if (ifA.busy !== 1'b0)        begin errors++; $display("[TB] FAIL mid_busy got %b want 0", ifA.busy); end
    checks++; if (ifA.done !== 1'b0)        begin errors++; $display("[TB] FAIL mid_done got %b want 0", ifA.done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    b0 = nBytesA; s0 = startsA;
    applyStimulus(1'b0);
    for (int i = 0; i < 5000 && !(ifA.done || ifA.error); i++) @(negedge clk);
    checks++; if (ifA.done !== 1'b1) begin errors++; $display("[TB] FAIL mid_restart_done got %b want 1", ifA.done); end
    checks++; if (startsA - s0 != 3) begin errors++; $display("[TB] FAIL mid_restart_writes got %0d want 3", startsA - s0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bytesA[(b0 + k) % 256] !== expB[k]) begin
        errors++; $display("[TB] FAIL mid_restart_byte%0d got %h want %h", k, bytesA[(b0 + k) % 256], expB[k]);
      end
    end
  endtask

  initial begin
    ifA.start = 1'b0; ifB.start = 1'b0;
    ifA.table_size = 8'd3; ifB.table_size = 8'd3;
    ifA.sccb_sda_in = 1'b1;
    ifB.sccb_sda_in = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = 16'h0000;
    test_reset();
    test_sequence();
    test_delay_tag();
    test_start_ignored();
    test_nack_retry();
    test_size_zero();
    test_nack_once();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
